// File: rtl/alu_exec.sv
// Execute stage feeding the 8x16 register file write port.
// Single-cycle ALU ops retire in one cycle; MUL is a 16-step shift-add.
module alu_exec #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  opA,
    input  logic [WIDTH-1:0]  opB,
    input  logic [ADDR_W-1:0] dstAddr,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [ADDR_W-1:0] wbAddr,
    output logic              WE,
    output logic              zero,
    output logic              carry
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0]  acc_q, acc_d, acc_step;
    logic [ACC_W-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [WIDTH-1:0]  result_d;
    logic [ADDR_W-1:0] wbaddr_d;
    logic              zero_d, carry_d;
    logic              busy_d, done_d;

    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;
    logic [WIDTH:0]    sum_w, diff_w, shl_w;
    logic [CNT_W-1:0]  shamt;

    // Single-cycle ALU; SHL keeps one extra bit so the last bit shifted out lands in bit WIDTH
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        shamt     = opB[CNT_W-1:0];
        sum_w     = {1'b0, opA} + {1'b0, opB};
        diff_w    = {1'b0, opA} - {1'b0, opB};
        shl_w     = {1'b0, opA} << shamt;
        case (op)
            OP_ADD: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff_w[WIDTH-1:0];
                alu_carry = diff_w[WIDTH];
            end
            OP_AND:   alu_res = opA & opB;
            OP_OR:    alu_res = opA | opB;
            OP_XOR:   alu_res = opA ^ opB;
            OP_SHL: begin
                alu_res   = shl_w[WIDTH-1:0];
                alu_carry = shl_w[WIDTH];
            end
            OP_PASSB: alu_res = opB;
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        dst_d    = dst_q;
        result_d = result;
        wbaddr_d = wbAddr;
        zero_d   = zero;
        carry_d  = carry;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dst_d = dstAddr;
                    if (op == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, opA};
                        mplier_d = opB;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        zero_d   = (alu_res == '0);
                        wbaddr_d = dstAddr;
                        state_d  = S_WB;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d = acc_step[WIDTH-1:0];
                    carry_d  = |acc_step[ACC_W-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                    wbaddr_d = dst_q;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_WB);
    end

    // State register with registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Datapath and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            dst_q    <= '0;
            result   <= '0;
            wbAddr   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
            result   <= result_d;
            wbAddr   <= wbaddr_d;
            zero     <= zero_d;
            carry    <= carry_d;
        end
    end

    assign WE = done;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: countdown reference model checked every cycle,
// directed literal cases from the test plan, then random traffic with resets.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] opA, opB;
    logic [2:0]  dstAddr;
    logic        busy, done, WE, zero, carry;
    logic [15:0] result;
    logic [2:0]  wbAddr;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
        .dstAddr(dstAddr), .busy(busy), .done(done), .result(result),
        .wbAddr(wbAddr), .WE(WE), .zero(zero), .carry(carry)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [15:0] rf [8] = '{default: 16'hAAAA};
    always @(negedge clk) if (WE === 1'b1) rf[wbAddr] <= result;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference arithmetic straight from the op definitions
    function automatic void ref_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic c);
        logic [31:0] w;
        int amt;
        r = 16'h0; c = 1'b0; w = 32'h0;
        case (o)
            3'd0: begin w = 32'(a) + 32'(b); r = w[15:0]; c = (w > 32'hFFFF); end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                amt = int'(b[3:0]);
                w = 32'(a) << amt;
                r = w[15:0];
                c = (amt == 0) ? 1'b0 : (((a >> (16 - amt)) & 16'h1) != 16'h0);
            end
            3'd6: begin w = 32'(a) * 32'(b); r = w[15:0]; c = (w[31:16] != 16'h0); end
            default: r = b;
        endcase
    endfunction

    // Model: m_wait counts cycles left until retirement (1 = writeback cycle)
    int          m_wait = 0;
    logic [15:0] p_res = 16'h0, e_res = 16'h0;
    logic        p_c = 1'b0, e_c = 1'b0, e_z = 1'b0;
    logic [2:0]  p_addr = 3'h0, e_addr = 3'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_wait = 0; e_res = 16'h0; e_c = 1'b0; e_z = 1'b0; e_addr = 3'h0;
        end else if (m_wait == 0) begin
            if (start) begin
                ref_op(op, opA, opB, p_res, p_c);
                p_addr = dstAddr;
                m_wait = (op == 3'd6) ? 17 : 1;
            end
        end else begin
            m_wait--;
        end
        if (!rst && m_wait == 1) begin
            e_res = p_res; e_c = p_c; e_z = (p_res == 16'h0); e_addr = p_addr;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   32'(busy),   32'(m_wait != 0));
            chk("done",   32'(done),   32'(m_wait == 1));
            chk("WE",     32'(WE),     32'(m_wait == 1));
            chk("result", 32'(result), 32'(e_res));
            chk("wbAddr", 32'(wbAddr), 32'(e_addr));
            chk("zero",   32'(zero),   32'(e_z));
            chk("carry",  32'(carry),  32'(e_c));
        end
    end

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h0001;
            4: return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    // Present one request; returns at the sampling point of the first cycle after accept
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b; dstAddr = d;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); opA = 16'($urandom); opB = 16'($urandom); dstAddr = 3'($urandom);
    endtask

    task automatic wait_done(input int maxc, output int lat, output int bcnt);
        int  i;
        bit  found;
        lat = 0; bcnt = 0; found = 1'b0; i = 1;
        while (!found && i <= maxc) begin
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                found = 1'b1;
                lat = i;
            end else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    task automatic do_op(input string nm, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] d, input logic [15:0] er, input logic ez, input logic ec, input int elat);
        int lat, bc;
        issue(o, a, b, d);
        wait_done(40, lat, bc);
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_busycyc"}, 32'(bc), 32'(elat));
        chk({nm, "_result"}, 32'(result), 32'(er));
        chk({nm, "_zero"},   32'(zero),   32'(ez));
        chk({nm, "_carry"},  32'(carry),  32'(ec));
        chk({nm, "_wbAddr"}, 32'(wbAddr), 32'(d));
        chk({nm, "_WE"},     32'(WE),     32'(1));
        @(negedge clk);
        chk({nm, "_WE_off"}, 32'(WE),     32'(0));
        chk({nm, "_idle"},   32'(busy),   32'(0));
        chk({nm, "_rf"},     32'(rf[d]),  32'(er));
    endtask

    initial begin
        int dc, dcyc, bc;
        logic [15:0] got;

        rst = 1'b1; start = 1'b0; op = 3'd0; opA = 16'h0; opB = 16'h0; dstAddr = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_done",   32'(done),   32'(0));
        chk("rst_WE",     32'(WE),     32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_wbAddr", 32'(wbAddr), 32'(0));
        chk("rst_zero",   32'(zero),   32'(0));
        chk("rst_carry",  32'(carry),  32'(0));
        rst = 1'b0;
        chk_en = 1'b1;

        do_op("add_carry", 3'd0, 16'hFFFF, 16'h0001, 3'd5, 16'h0000, 1'b1, 1'b1, 1);
        do_op("sub_borrow", 3'd1, 16'h0002, 16'h0003, 3'd1, 16'hFFFF, 1'b0, 1'b1, 1);
        do_op("shl_out",   3'd5, 16'h8001, 16'h0001, 3'd2, 16'h0002, 1'b0, 1'b1, 1);
        do_op("shl_zero",  3'd5, 16'h1234, 16'h0010, 3'd3, 16'h1234, 1'b0, 1'b0, 1);
        do_op("shl_15",    3'd5, 16'hFFFF, 16'h000F, 3'd4, 16'h8000, 1'b0, 1'b1, 1);
        do_op("and",       3'd2, 16'hF0F0, 16'hFF00, 3'd0, 16'hF000, 1'b0, 1'b0, 1);
        do_op("xor_zero",  3'd4, 16'hAAAA, 16'hAAAA, 3'd6, 16'h0000, 1'b1, 1'b0, 1);
        do_op("passb",     3'd7, 16'h1111, 16'h00C3, 3'd7, 16'h00C3, 1'b0, 1'b0, 1);
        do_op("mul_small", 3'd6, 16'h0003, 16'h0005, 3'd1, 16'h000F, 1'b0, 1'b0, 17);
        do_op("mul_ovf",   3'd6, 16'h0100, 16'h0100, 3'd2, 16'h0000, 1'b1, 1'b1, 17);
        do_op("mul_max",   3'd6, 16'hFFFF, 16'hFFFF, 3'd3, 16'h0001, 1'b0, 1'b1, 17);

        // start held high mid-MUL must be ignored
        issue(3'd6, 16'h0003, 16'h0005, 3'd6);
        dc = 0; dcyc = 0; bc = 0; got = 16'h0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (done === 1'b1) begin dc++; dcyc = cyc; got = result; end
            if (busy === 1'b1) bc++;
            start = (cyc >= 3 && cyc <= 10);
            op = 3'd0; opA = 16'h0001; opB = 16'h0001; dstAddr = 3'd0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_start_done_count", 32'(dc), 32'(1));
        chk("busy_start_done_cycle", 32'(dcyc), 32'(17));
        chk("busy_start_busy_cycles", 32'(bc), 32'(17));
        chk("busy_start_result", 32'(got), 32'(16'h000F));

        // reset asserted in cycle N+8 of a MUL
        issue(3'd6, 16'h00FF, 16'h0101, 3'd7);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",   32'(busy),   32'(0));
        chk("abort_WE",     32'(WE),     32'(0));
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_wbAddr", 32'(wbAddr), 32'(0));
        chk("abort_zero",   32'(zero),   32'(0));
        chk("abort_carry",  32'(carry),  32'(0));
        rst = 1'b0;
        dc = 0;
        repeat (20) begin
            @(negedge clk);
            if (WE === 1'b1) dc++;
        end
        chk("abort_no_WE", 32'(dc), 32'(0));
        do_op("after_abort_add", 3'd0, 16'h0001, 16'h0002, 3'd2, 16'h0003, 1'b0, 1'b0, 1);

        // Random traffic, including starts while busy and occasional resets
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 149) == 0);
            start   = 1'($urandom_range(0, 1));
            op      = 3'($urandom_range(0, 7));
            opA     = pick();
            opB     = pick();
            dstAddr = 3'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
